// File: rtl/au_seq_if.sv
// au_seq_if: controller-side handshake and operand/flag bundle for au_seq.
// The tri-state result bus stays a plain port on the unit itself.
interface au_seq_if #(
  parameter int W = 8
);
  logic         au_en;
  logic         start;
  logic [3:0]   ac;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         gf;
  logic         cf;
  logic         zf;
  logic         busy;
  logic         done;

  modport master (
    output au_en, start, ac, a, b,
    input  gf, cf, zf, busy, done
  );

  modport slave (
    input  au_en, start, ac, a, b,
    output gf, cf, zf, busy, done
  );
endinterface

// File: rtl/au_seq.sv
// au_seq: clocked arithmetic unit (add, subtract/compare, pass-A, iterative multiply)
// with a tri-state result bus. Define AU_DIV_EN to add the W-cycle restoring divider.
module au_seq #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst,
  au_seq_if.slave     bus,
  output wire [W-1:0] t
);
  localparam int CW = $clog2(W + 1);

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_PA0 = 4'b0100;
  localparam logic [3:0] OP_PA1 = 4'b0101;
  localparam logic [3:0] OP_PA2 = 4'b1101;
`ifdef AU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1011;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  opa_q, opa_d;   // multiplicand / divisor
  logic [W-1:0]  hi_q, hi_d;     // partial product high half / remainder
  logic [W-1:0]  lo_q, lo_d;     // multiplier shifting out / quotient shifting in
  logic [W-1:0]  res_q, res_d;
  logic          gf_q, gf_d;
  logic          cf_q, cf_d;
  logic          zf_q, zf_d;
`ifdef AU_DIV_EN
  logic          is_div_q, is_div_d;
`endif

  // Single-cycle datapath, evaluated on the live operands at the accepting edge.
  logic [W:0]   add_full;
  logic [W:0]   sub_full;
  logic [W-1:0] sc_res;
  logic         sc_cf;
  logic         sc_gf;
  logic         sc_multi;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    add_full = {1'b0, bus.a} + {1'b0, bus.b};
    sub_full = {1'b0, bus.b} - {1'b0, bus.a};
    sc_res   = '0;
    sc_cf    = 1'b0;
    sc_gf    = 1'b0;
    sc_multi = 1'b0;
    case (bus.ac)
      OP_ADD: begin
        sc_res = add_full[W-1:0];
        sc_cf  = add_full[W];
      end
      OP_SUB: begin
        sc_res = sub_full[W-1:0];
        sc_cf  = sub_full[W];
        sc_gf  = $signed(bus.b) > $signed(bus.a);
      end
      OP_PA0, OP_PA1, OP_PA2: sc_res = bus.a;
      OP_MUL: sc_multi = 1'b1;
`ifdef AU_DIV_EN
      OP_DIV: sc_multi = 1'b1;
`endif
      default: ;
    endcase
  end

  // One iteration step: shift-add multiply, or restoring divide when enabled.
  logic [W:0]   mul_sum;
  logic [W-1:0] step_hi;
  logic [W-1:0] step_lo;
`ifdef AU_DIV_EN
  logic [W:0]   div_shift;
  logic [W-1:0] div_diff;
  logic         div_ok;
`endif

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    step_hi = mul_sum[W:1];
    step_lo = {mul_sum[0], lo_q[W-1:1]};
`ifdef AU_DIV_EN
    div_shift = {hi_q, lo_q[W-1]};
    div_ok    = div_shift >= {1'b0, opa_q};
    div_diff  = div_shift[W-1:0] - opa_q;
    if (is_div_q) begin
      step_hi = div_ok ? div_diff : div_shift[W-1:0];
      step_lo = {lo_q[W-2:0], div_ok};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    gf_d    = gf_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
`ifdef AU_DIV_EN
    is_div_d = is_div_q;
`endif
    case (state_q)
      RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          res_d   = step_lo;
          gf_d    = 1'b0;
          cf_d    = |step_hi;
          zf_d    = (step_lo == '0);
`ifdef AU_DIV_EN
          if (is_div_q) cf_d = (opa_q == '0);
`endif
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE lasts one cycle.
        state_d = IDLE;
        if (bus.start) begin
          opa_d = bus.a;
          hi_d  = '0;
          lo_d  = bus.b;
          if (sc_multi) begin
            state_d = RUN;
            cnt_d   = CW'(W);
`ifdef AU_DIV_EN
            is_div_d = bus.ac[0];
`endif
          end else begin
            state_d = DONE;
            res_d   = sc_res;
            gf_d    = sc_gf;
            cf_d    = sc_cf;
            zf_d    = (sc_res == '0);
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      gf_q    <= 1'b0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b1;
`ifdef AU_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      gf_q    <= gf_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
`ifdef AU_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.gf   = gf_q;
  assign bus.cf   = cf_q;
  assign bus.zf   = zf_q;
  assign t        = bus.au_en ? res_q : {W{1'bz}};

endmodule
